// File: rtl/noc_output_vc_mux.sv
// noc_output_vc_mux: merges per-VC flit streams onto one link with per-VC credit
// tracking and round-robin VC arbitration.
module noc_output_vc_mux #(
   parameter int CHANNELS = 32,
   parameter int FLIT_W   = 64,
   parameter int CREDITS  = 32
) (
   input  logic                         noc_clk,
   input  logic                         noc_rst,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   input  logic [CHANNELS*FLIT_W-1:0]   in_flit,
   output logic [CHANNELS-1:0]          out_valid,
   output logic [FLIT_W-1:0]            out_flit,
   input  logic [CHANNELS-1:0]          credit_return,
   output logic                         credit_err,
   output logic                         link_idle
);
   localparam int CW = $clog2(CREDITS + 1);
   localparam int PW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   logic [CW-1:0]       r_cnt [CHANNELS];
   logic [PW-1:0]       r_ptr;
   logic [CHANNELS-1:0] r_out_valid;
   logic [FLIT_W-1:0]   r_out_flit;
   logic                r_err;
   logic [CHANNELS-1:0] w_elig;
   logic [CHANNELS-1:0] w_grant;
   logic [PW-1:0]       w_gidx;
   logic [PW-1:0]       w_k;
   logic                w_any;
   logic                w_full;
   always_comb begin
      w_elig = '0;
      w_full = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         w_elig[i] = in_valid[i] && r_cnt[i] != '0 && !noc_rst;
         w_full = w_full && r_cnt[i] == CW'(CREDITS);
      end
   end
   // First eligible VC scanning upward from the pointer, wrapping at CHANNELS.
   always_comb begin
      w_any = 1'b0;
      w_gidx = r_ptr;
      w_k = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         w_k = PW'((int'(r_ptr) + k) % CHANNELS);
         if (!w_any && w_elig[w_k]) begin
            w_any = 1'b1;
            w_gidx = w_k;
         end
      end
      w_grant = w_any ? CHANNELS'(1) << w_gidx : '0;
   end
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         r_ptr <= '0;
         r_out_valid <= '0;
         r_out_flit <= '0;
         r_err <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= CW'(CREDITS);
      end else begin
         r_out_valid <= w_grant;
         if (w_any) begin
            r_out_flit <= in_flit[int'(w_gidx)*FLIT_W +: FLIT_W];
            r_ptr <= int'(w_gidx) == CHANNELS - 1 ? '0 : w_gidx + PW'(1);
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i] && !credit_return[i])
               r_cnt[i] <= r_cnt[i] - CW'(1);
            else if (credit_return[i] && !w_grant[i]) begin
               if (r_cnt[i] == CW'(CREDITS)) r_err <= 1'b1;
               else r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end
   assign in_ready   = w_grant;
   assign out_valid  = r_out_valid;
   assign out_flit   = r_out_flit;
   assign credit_err = r_err;
   assign link_idle  = w_full && r_out_valid == '0;
endmodule

// File: tb/tb_noc_output_vc_mux.sv
// tb_noc_output_vc_mux: directed checks of arbitration, credits, latency and reset.
module tb_noc_output_vc_mux;
   localparam int CH = 32;
   localparam int FW = 64;
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CH-1:0]     in_valid = '0;
   logic [CH-1:0]     in_ready;
   logic [CH*FW-1:0]  in_flit;
   logic [CH-1:0]     out_valid;
   logic [FW-1:0]     out_flit;
   logic [CH-1:0]     credit_return = '0;
   logic              credit_err;
   logic              link_idle;
   int                n_chk = 0;
   int                n_fail = 0;

   noc_output_vc_mux #(.CHANNELS(CH), .FLIT_W(FW), .CREDITS(32)) dut (
      .noc_clk(clk), .noc_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_flit(in_flit), .out_valid(out_valid), .out_flit(out_flit),
      .credit_return(credit_return), .credit_err(credit_err), .link_idle(link_idle));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   function automatic logic all_full();
      logic f = 1'b1;
      for (int i = 0; i < CH; i++) f = f && dut.r_cnt[i] == 6'd32;
      return f;
   endfunction

   initial begin
      int seq [6] = '{0, 1, 5, 0, 1, 5};
      int n;
      for (int i = 0; i < CH; i++) in_flit[i*FW +: FW] = 64'h100 + 64'(i);
      in_flit[3*FW +: FW] = 64'hA5;
      in_valid = '1;
      #2;
      chk("ready_in_reset", 64'(in_ready), 64'h0);
      in_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("t1_link_idle", 64'(link_idle), 64'h1);
      chk("t1_in_ready", 64'(in_ready), 64'h0);
      chk("t1_out_valid", 64'(out_valid), 64'h0);
      chk("t1_cnt_full", 64'(all_full()), 64'h1);
      chk("t1_ptr", 64'(dut.r_ptr), 64'h0);

      in_valid = 32'h8;
      #1;
      chk("t2_ready_same_cycle", 64'(in_ready), 64'h8);
      step();
      in_valid = '0;
      chk("t2_out_valid", 64'(out_valid), 64'h8);
      chk("t2_out_flit", out_flit, 64'hA5);
      chk("t2_not_idle", 64'(link_idle), 64'h0);
      chk("t2_cnt3", 64'(dut.r_cnt[3]), 64'd31);
      credit_return = 32'h8;
      step();
      credit_return = '0;
      chk("t2_idle_valid", 64'(out_valid), 64'h0);
      chk("t2_flit_hold", out_flit, 64'hA5);
      chk("t2_idle_back", 64'(link_idle), 64'h1);

      do_reset();
      in_valid = 32'h23;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t3_rr_grant", 64'(in_ready), 64'(32'(1) << seq[k]));
         step();
         chk("t3_out_tag", 64'(out_valid), 64'(32'(1) << seq[k]));
         chk("t3_out_flit", out_flit, 64'h100 + 64'(seq[k]));
      end
      in_valid = '0;

      do_reset();
      in_valid = 32'h4;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (in_ready[2]) n++;
         step();
      end
      chk("t4_transfers", 64'(n), 64'd32);
      chk("t4_ready_off", 64'(in_ready), 64'h0);
      chk("t4_cnt_zero", 64'(dut.r_cnt[2]), 64'd0);
      credit_return = 32'h4;
      #1;
      chk("t4_no_comb_credit", 64'(in_ready), 64'h0);
      step();
      credit_return = '0;
      n = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (in_ready[2]) n++;
         step();
      end
      chk("t4_extra_transfer", 64'(n), 64'd1);
      in_valid = '0;

      do_reset();
      in_valid = 32'h80;
      repeat (27) step();
      chk("t5_cnt5", 64'(dut.r_cnt[7]), 64'd5);
      credit_return = 32'h80;
      #1;
      chk("t5_grant_with_return", 64'(in_ready), 64'h80);
      step();
      in_valid = '0;
      credit_return = '0;
      chk("t5_cnt_stays5", 64'(dut.r_cnt[7]), 64'd5);
      credit_return = 32'h80;
      repeat (27) step();
      chk("t5_cnt_back32", 64'(dut.r_cnt[7]), 64'd32);
      chk("t5_no_err_yet", 64'(credit_err), 64'h0);
      step();
      credit_return = '0;
      chk("t5_cnt_saturate", 64'(dut.r_cnt[7]), 64'd32);
      chk("t5_err_set", 64'(credit_err), 64'h1);
      repeat (3) step();
      chk("t5_err_sticky", 64'(credit_err), 64'h1);

      in_valid = 32'h4;
      step();
      chk("t6_inflight", 64'(out_valid), 64'h4);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_async_drop", 64'(out_valid), 64'h0);
      chk("t6_ready_in_reset", 64'(in_ready), 64'h0);
      in_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("t6_cnt_full", 64'(all_full()), 64'h1);
      chk("t6_ptr", 64'(dut.r_ptr), 64'h0);
      chk("t6_err_clear", 64'(credit_err), 64'h0);
      chk("t6_idle", 64'(link_idle), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
